// File: rtl/gate_truth_table_checker.sv
// Hardware self-test sequencer for a combinational gate under test (GUT).
// It drives every input vector in ascending order. Each vector is held for
// SETTLE cycles and then the GUT output is sampled in one CHECK cycle. That
// sample is compared with TRUTH[vector]. At the end of the sweep the block
// reports a pass flag, the number of mismatches and the lowest failing vector.
//
// Handshake: start is a single-cycle request. It is only looked at in IDLE.
// busy is high from the cycle after start is accepted up to and including the
// DONE cycle. done pulses for exactly that DONE cycle. The results stay
// stable from DONE until the next accepted start or a reset.
module gate_truth_table_checker #(
  parameter int                      N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]    TRUTH  = 4'b1000,
  parameter int                      SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] gut_in,
  input  logic            gut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld,
  output logic [1:0]      dbg_state
);

  localparam int WW = $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [WW-1:0]   wcnt;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Compare the GUT output with the expected truth-table bit for the current vector.
  always_comb begin
    mismatch = (gut_out != TRUTH[vec]);
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
  end

  assign dbg_state = state;

  // Sweep FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      vec            <= '0;
      wcnt           <= '0;
      gut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec            <= '0;
            gut_in         <= '0;
            wcnt           <= WW'(SETTLE);
            err_count      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The vector stays on gut_in for SETTLE full cycles before the sample cycle.
          wcnt <= wcnt - WW'(1);
          if (wcnt == WW'(1)) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_next;
            if (!first_fail_vld) begin
              first_fail     <= vec;
              first_fail_vld <= 1'b1;
            end
          end
          if (vec == LAST_VEC) begin
            // The last vector is all-ones. The sweep ends here and never wraps.
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            vec    <= vec + N_IN'(1);
            gut_in <= vec + N_IN'(1);
            wcnt   <= WW'(SETTLE);
            state  <= S_WAIT;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
